isqrt_pipe: RTL and testbench
=============================

Name: isqrt_pipe

Overview:
- Fully pipelined integer square-root unit: out_root = floor(sqrt(in_x)) for an unsigned in_x of WIDTH bits.
- One pipeline stage resolves one root bit, MSB first. Each stage compares the operand against (partial_root | trial_bit)^2.
- Adds a valid/ready handshake with backpressure, and passes the original operand through alongside the result.
- Sits between sample-processing front-ends and downstream magnitude/normalisation logic.

Parameters:
- WIDTH, 16, operand width in bits. Must be even and ≥ 4; elaboration error otherwise.
- ROOT_W, WIDTH/2, derived root width and stage count N. Not overridable.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  synchronous active-low reset.
- in_valid  in  1  in_x is valid this cycle.
- in_ready  out  1  pipeline can accept in_x this cycle.
- in_x  in  WIDTH  unsigned operand.
- out_valid  out  1  out_root/out_x are valid.
- out_ready  in  1  downstream accepts the result this cycle.
- out_root  out  ROOT_W  floor(sqrt(operand)).
- out_x  out  WIDTH  the operand that produced out_root.
- out_rem  out  ROOT_W+1  operand − root²; present only with ISQRT_REM_EN.

Behaviour:
- Reset:
  - rst_n low at a rising clk edge clears every stage valid bit, out_valid, out_root, out_x, out_rem and all partial-root registers to 0.
  - Asynchronous assertion has no effect until the next edge.
  - Reset mid-operation discards all in-flight operands; nothing is emitted for them.
- Pipeline:
  - N = ROOT_W register stages. Stage k (k = 0..N−1) decides root bit b = N−1−k.
  - trial = partial | (1<<b); set bit b iff operand ≥ trial², an unsigned compare at full WIDTH.
  - Implementation may use restoring/non-restoring remainder arithmetic instead of squaring, but results must be bit-exact to floor(sqrt).
  - Each stage carries its operand copy, its partial root and a valid bit.
- Latency: an operand accepted at edge t (in_valid & in_ready) appears with out_valid = 1 after edge t+N, provided no stall occurs. Throughput is 1 result per cycle.
- Handshake:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall, combinational from out_valid and out_ready only; it must not depend on in_valid.
  - On stall, all stages hold, including bubbles. No data is lost or duplicated.
  - out_root, out_x and out_rem are stable while out_valid = 1 and out_ready = 0.
  - A transfer occurs on an edge with out_valid & out_ready.
- Bubbles: in_valid = 0 while in_ready = 1 inserts a bubble (valid = 0) that advances normally. When out_valid = 0, out_* hold their last values and must not be sampled.
- Simultaneous events: output transfer and input acceptance in the same cycle are both honoured; pipeline occupancy is unchanged.
- Boundaries:
  - in_x = 0 gives root 0.
  - in_x = 2^WIDTH−1 gives root 2^ROOT_W−1.
  - Exact squares give the exact root.
  - The max remainder, 2·root, fits in ROOT_W+1 bits.
  - trial² never exceeds 2^WIDTH − 2^(ROOT_W+1) + 1, so the compare never overflows.

Optional Feature:
- Macro: ISQRT_REM_EN.
- Defined:
  - Port out_rem exists and equals out_x − out_root², registered in the final stage.
  - It resets to 0, holds under stall, and has the same latency as out_root.
- Undefined:
  - Port out_rem is absent, and no remainder or square datapath is carried beyond what the root itself needs.
  - All other behaviour is identical.

Test Plan:
- WIDTH=16, out_ready=1. Single operands 0, 1, 255, 256, 65535, each followed by idle cycles:
  - Roots 0, 1, 15, 16, 255, each arriving exactly 8 cycles after acceptance.
  - Remainders (REM_EN) 0, 0, 30, 0, 510.
  - out_x echoes the operand.
- Back-to-back stream in_x = 0..1023 with in_valid held high, out_ready = 1:
  - After 8-cycle fill, out_valid stays high for 1024 consecutive cycles.
  - Each out_root = floor(sqrt(out_x)); order is preserved.
- Backpressure:
  - Stream 100, 121, 144, ...; hold out_ready = 0 for 5 cycles once out_valid rises.
  - in_ready = 0 during the hold, and out_root stays 10 throughout.
  - After release the sequence continues 11, 12 with no gaps or duplicates.
- Bubbles: alternate in_valid 1/0 with random out_ready → scoreboard matches a reference model one-for-one; no extra out_valid pulses.
- Reset mid-stream:
  - Drive rst_n = 0 for 1 edge with 5 operands in flight.
  - Next cycle: out_valid = 0 and out_root/out_x = 0.
  - No in-flight result emerges; a fresh operand 49 yields root 7 after 8 cycles.
- Parameter sweep WIDTH = 4, 8, 32 with random operands → bit-exact roots; latency is 2, 4 and 16 cycles respectively.

Source files
------------

// File: rtl/isqrt_pipe.sv
// -----------------------------------------------------------------------------
// isqrt_pipe
//
// Fully pipelined integer square root: out_root = floor(sqrt(in_x)) for an
// unsigned WIDTH-bit operand.
//
// Pipeline shape:
//   - An input register (stage 0) captures the accepted operand.
//   - ROOT_W decision stages follow. Stage k settles root bit ROOT_W-k, MSB first.
//   - An operand accepted on edge t is presented on edge t+ROOT_W.
//   - Throughput is one result per cycle.
//
// Handshake: valid/ready with backpressure.
//   - in_ready depends only on out_valid and out_ready.
//   - While the output is stalled, every stage holds, including bubbles.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operand on in_x is valid
//   in_ready   pipeline accepts an operand this cycle
//   in_x       unsigned operand, WIDTH bits
//   out_valid  out_root/out_x (and out_rem) are valid
//   out_ready  downstream accepts the result this cycle
//   out_root   floor(sqrt(operand)), ROOT_W bits
//   out_x      operand that produced out_root
//   out_rem    operand - root^2, ROOT_W+1 bits (only with ISQRT_REM_EN)
//
// Optional feature macro: ISQRT_REM_EN
//   Adds the out_rem port and its final-stage datapath.
// -----------------------------------------------------------------------------
module isqrt_pipe #(
  parameter  int WIDTH  = 16,
  localparam int ROOT_W = WIDTH / 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  in_x,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ROOT_W-1:0] out_root,
  output logic [WIDTH-1:0]  out_x
`ifdef ISQRT_REM_EN
  ,
  output logic [ROOT_W:0]   out_rem
`endif
);

  localparam int REM_W = ROOT_W + 1;

  if (((WIDTH % 2) != 0) || (WIDTH < 4)) begin : g_width_check
    $error("isqrt_pipe: WIDTH must be even and at least 4");
  end

  logic              stall_s;
  logic              valid_r [0:ROOT_W];
  logic [WIDTH-1:0]  x_r     [0:ROOT_W];
  logic [ROOT_W-1:0] root_r  [0:ROOT_W];

`ifdef ISQRT_REM_EN
  logic [REM_W-1:0]  rem_r;
  assign out_rem = rem_r;
`endif

  assign stall_s   = valid_r[ROOT_W] & ~out_ready;
  assign in_ready  = ~stall_s;
  assign out_valid = valid_r[ROOT_W];
  assign out_root  = root_r[ROOT_W];
  assign out_x     = x_r[ROOT_W];

  // Stage 0: capture the accepted operand; its partial root is always zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_r[0] <= 1'b0;
      x_r[0]     <= '0;
      root_r[0]  <= '0;
    end else if (!stall_s) begin
      valid_r[0] <= in_valid;
      root_r[0]  <= '0;
      // Data registers load only on real operands.
      // Bubbles therefore leave the last result visible on out_*.
      if (in_valid) begin
        x_r[0] <= in_x;
      end
    end
  end

  for (genvar k = 1; k <= ROOT_W; k++) begin : g_stage
    localparam int BIT = ROOT_W - k;

    logic [ROOT_W-1:0] trial_s;
    logic [WIDTH-1:0]  trial_sq_s;
    logic [ROOT_W-1:0] root_nxt_s;

    // Trial the next root bit.
    // trial^2 always fits in WIDTH bits, so the compare cannot overflow.
    always_comb begin
      trial_s    = root_r[k-1] | (ROOT_W'(1) << BIT);
      trial_sq_s = WIDTH'(trial_s) * WIDTH'(trial_s);
      if (x_r[k-1] >= trial_sq_s) begin
        root_nxt_s = trial_s;
      end else begin
        root_nxt_s = root_r[k-1];
      end
    end

    // Advance operand, partial root and valid bit unless the output is stalled.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        valid_r[k] <= 1'b0;
        x_r[k]     <= '0;
        root_r[k]  <= '0;
      end else if (!stall_s) begin
        valid_r[k] <= valid_r[k-1];
        if (valid_r[k-1]) begin
          x_r[k]    <= x_r[k-1];
          root_r[k] <= root_nxt_s;
        end
      end
    end

`ifdef ISQRT_REM_EN
    if (k == ROOT_W) begin : g_rem
      logic [WIDTH-1:0] root_sq_s;

      // Square of the finished root.
      // It is used only to form the remainder.
      always_comb begin
        root_sq_s = WIDTH'(root_nxt_s) * WIDTH'(root_nxt_s);
      end

      // Register the remainder alongside the final root.
      // The remainder is at most 2*root, so it fits in REM_W bits.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          rem_r <= '0;
        end else if (!stall_s) begin
          if (valid_r[k-1]) begin
            rem_r <= REM_W'(x_r[k-1] - root_sq_s);
          end
        end
      end
    end
`endif
  end

endmodule

// File: tb/tb_isqrt_pipe.sv
// -----------------------------------------------------------------------------
// tb_isqrt_pipe
//
// Scoreboard bench for isqrt_pipe.
//   - Stimulus pushes the expected result into a queue when an operand is
//     accepted.
//   - A negedge monitor compares the queue head against every valid output
//     cycle, and pops it on a transfer.
//   - Extra instances at WIDTH = 4, 8 and 32 check roots and latency.
// -----------------------------------------------------------------------------
module tb_isqrt_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_root;
  logic [15:0] out_x;
`ifdef ISQRT_REM_EN
  logic [8:0]  out_rem;
`endif

  isqrt_pipe #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_root  (out_root),
    .out_x     (out_x)
`ifdef ISQRT_REM_EN
    ,
    .out_rem   (out_rem)
`endif
  );

  // Width-sweep instances, always ready downstream.
  logic        sv;
  logic [3:0]  sx4;
  logic [7:0]  sx8;
  logic [31:0] sx32;
  logic        sir4, sir8, sir32;
  logic        sov4, sov8, sov32;
  logic [1:0]  sroot4;
  logic [3:0]  sroot8;
  logic [15:0] sroot32;
  logic [3:0]  sox4;
  logic [7:0]  sox8;
  logic [31:0] sox32;
`ifdef ISQRT_REM_EN
  logic [2:0]  srem4;
  logic [4:0]  srem8;
  logic [16:0] srem32;
`endif

  isqrt_pipe #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(sv), .in_ready(sir4), .in_x(sx4),
    .out_valid(sov4), .out_ready(1'b1), .out_root(sroot4), .out_x(sox4)
`ifdef ISQRT_REM_EN
    , .out_rem(srem4)
`endif
  );

  isqrt_pipe #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(sv), .in_ready(sir8), .in_x(sx8),
    .out_valid(sov8), .out_ready(1'b1), .out_root(sroot8), .out_x(sox8)
`ifdef ISQRT_REM_EN
    , .out_rem(srem8)
`endif
  );

  isqrt_pipe #(.WIDTH(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(sv), .in_ready(sir32), .in_x(sx32),
    .out_valid(sov32), .out_ready(1'b1), .out_root(sroot32), .out_x(sox32)
`ifdef ISQRT_REM_EN
    , .out_rem(srem32)
`endif
  );

  typedef struct {
    logic [15:0] x;
    logic [7:0]  root;
    logic [8:0]  rem;
    bit          lc;
    int          acc;
  } exp_t;

  exp_t sbq[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  // Edge counter used to measure latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int isqrt_ref(input int x);
    int r = 0;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // Monitor: compare every valid output cycle against the queue head; pop on transfer.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        chk("unexpected_out_valid", 64'd1, 64'd0);
      end else begin
        chk("out_x", out_x, sbq[0].x);
        chk("out_root", out_root, sbq[0].root);
`ifdef ISQRT_REM_EN
        chk("out_rem", out_rem, sbq[0].rem);
`endif
        if (out_ready === 1'b1) begin
          if (sbq[0].lc) chk("latency", cyc - sbq[0].acc, 64'd8);
          void'(sbq.pop_front());
        end
      end
    end
  end

  // Present one operand at posedge+1 and hold it until accepted.
  task automatic send(input logic [15:0] x, input logic [7:0] r, input logic [8:0] m, input bit lc);
    bit   acc = 1'b0;
    int   g   = 0;
    exp_t e;
    in_x     = x;
    in_valid = 1'b1;
    do begin
      @(negedge clk);
      acc = (in_ready === 1'b1);
      if (acc) begin
        e.x = x; e.root = r; e.rem = m; e.lc = lc; e.acc = cyc + 1;
        sbq.push_back(e);
      end
      @(posedge clk); #1;
      g++;
    end while (!acc && g < 200);
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic wait_empty();
    int g = 0;
    while (sbq.size() != 0 && g < 300) begin @(posedge clk); #1; g++; end
    chk("drain", sbq.size(), 64'd0);
  endtask

  logic [15:0] s_x [5] = '{16'd0, 16'd1, 16'd255, 16'd256, 16'd65535};
  logic [7:0]  s_r [5] = '{8'd0, 8'd1, 8'd15, 8'd16, 8'd255};
  logic [8:0]  s_m [5] = '{9'd0, 9'd0, 9'd30, 9'd0, 9'd510};

  logic [3:0]  v4x  [6] = '{4'd0, 4'd3, 4'd4, 4'd15, 4'd9, 4'd8};
  logic [1:0]  v4r  [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd2};
  logic [2:0]  v4m  [6] = '{3'd0, 3'd2, 3'd0, 3'd6, 3'd0, 3'd4};
  logic [7:0]  v8x  [6] = '{8'd0, 8'd255, 8'd224, 8'd100, 8'd99, 8'd1};
  logic [3:0]  v8r  [6] = '{4'd0, 4'd15, 4'd14, 4'd10, 4'd9, 4'd1};
  logic [4:0]  v8m  [6] = '{5'd0, 5'd30, 5'd28, 5'd0, 5'd18, 5'd0};
  logic [31:0] v32x [6] = '{32'd0, 32'd4294967295, 32'd4294836225, 32'd4294836224, 32'd1000000, 32'd999999};
  logic [15:0] v32r [6] = '{16'd0, 16'd65535, 16'd65535, 16'd65534, 16'd1000, 16'd999};
  logic [16:0] v32m [6] = '{17'd0, 17'd131070, 17'd0, 17'd131068, 17'd0, 17'd1998};

  logic [1:0]  r4;
  logic [3:0]  r8;
  logic [15:0] r32;
  logic [2:0]  m4;
  logic [4:0]  m8;
  logic [16:0] m32;
  int          l4, l8, l32;
  bit          bdone;

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_x = 16'd0; out_ready = 1'b1;
    sv = 1'b0; sx4 = 4'd0; sx8 = 8'd0; sx32 = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 64'd0);
    chk("rst_out_root", out_root, 64'd0);
    chk("rst_out_x", out_x, 64'd0);
    chk("rst_in_ready", in_ready, 64'd1);
`ifdef ISQRT_REM_EN
    chk("rst_out_rem", out_rem, 64'd0);
`endif
    rst_n = 1'b1;
    idle(1);

    // Isolated operands with latency check.
    for (int i = 0; i < 5; i++) begin
      send(s_x[i], s_r[i], s_m[i], 1'b1);
      idle(12);
    end
    wait_empty();

    // Back-to-back stream 0..1023.
    fork
      begin
        for (int i = 0; i < 1024; i++) begin
          int r;
          r = isqrt_ref(i);
          send(16'(i), 8'(r), 9'(i - r * r), 1'b0);
        end
      end
      begin
        int g   = 0;
        int run = 0;
        while (out_valid !== 1'b1 && g < 40) begin @(posedge clk); #1; g++; end
        while (out_valid === 1'b1 && run < 1100) begin run++; @(posedge clk); #1; end
        chk("stream_run_length", run, 64'd1024);
      end
    join
    wait_empty();

    // Backpressure: perfect squares 10^2..21^2, stall 5 cycles on the first result.
    fork
      begin
        for (int i = 10; i < 22; i++) send(16'(i * i), 8'(i), 9'd0, 1'b0);
      end
      begin
        int g = 0;
        while (out_valid !== 1'b1 && g < 50) begin @(posedge clk); #1; g++; end
        out_ready = 1'b0;
        repeat (5) begin
          @(negedge clk);
          chk("bp_in_ready", in_ready, 64'd0);
          chk("bp_root_hold", out_root, 64'd10);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    wait_empty();

    // Bubbles with random backpressure.
    bdone = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          int x, r;
          x = (i * 1637 + 11) % 65536;
          r = isqrt_ref(x);
          send(16'(x), 8'(r), 9'(x - r * r), 1'b0);
          idle(1);
        end
        bdone = 1'b1;
      end
      begin
        while (!bdone) begin @(posedge clk); #1; out_ready = 1'($urandom_range(0, 1)); end
        out_ready = 1'b1;
      end
    join
    wait_empty();

    // Reset with five operands in flight.
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send(16'(1000 + i), 8'd0, 9'd0, 1'b0);
    rst_n = 1'b0;
    sbq.delete();
    @(posedge clk); #1;
    chk("mid_rst_out_valid", out_valid, 64'd0);
    chk("mid_rst_out_root", out_root, 64'd0);
    chk("mid_rst_out_x", out_x, 64'd0);
    rst_n = 1'b1;
    idle(12);
    send(16'd49, 8'd7, 9'd0, 1'b1);
    idle(12);
    wait_empty();

    // Width sweep: roots and latency of 2, 4 and 16 cycles.
    for (int i = 0; i < 6; i++) begin
      sx4 = v4x[i]; sx8 = v8x[i]; sx32 = v32x[i]; sv = 1'b1;
      @(posedge clk); #1;
      sv = 1'b0;
      l4 = -1; l8 = -1; l32 = -1;
      r4 = 2'd0; r8 = 4'd0; r32 = 16'd0; m4 = 3'd0; m8 = 5'd0; m32 = 17'd0;
      for (int c = 1; c <= 20; c++) begin
        @(posedge clk); #1;
        if (sov4 === 1'b1 && l4 < 0) begin
          l4 = c; r4 = sroot4;
`ifdef ISQRT_REM_EN
          m4 = srem4;
`endif
        end
        if (sov8 === 1'b1 && l8 < 0) begin
          l8 = c; r8 = sroot8;
`ifdef ISQRT_REM_EN
          m8 = srem8;
`endif
        end
        if (sov32 === 1'b1 && l32 < 0) begin
          l32 = c; r32 = sroot32;
`ifdef ISQRT_REM_EN
          m32 = srem32;
`endif
        end
      end
      chk("w4_root", r4, v4r[i]);
      chk("w4_latency", l4, 64'd2);
      chk("w8_root", r8, v8r[i]);
      chk("w8_latency", l8, 64'd4);
      chk("w32_root", r32, v32r[i]);
      chk("w32_latency", l32, 64'd16);
`ifdef ISQRT_REM_EN
      chk("w4_rem", m4, v4m[i]);
      chk("w8_rem", m8, v8m[i]);
      chk("w32_rem", m32, v32m[i]);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
